sprite_palette_engine: RTL and testbench
========================================

Name: sprite_palette_engine

Overview:
- Multi-bank, runtime-writable sprite colour palette with a registered lookup pipeline and a screen-fade brightness engine.
- Sits between the per-sprite ROM index readers and the VGA colour mux.
- Each pixel supplies a palette bank select plus a colour index. The block returns 12-bit RGB, a transparency flag and a valid strobe, 2 cycles later.
- Replaces the fixed single-sprite combinational palettes: one engine serves all Link/enemy frames.

Parameters:
- NUM_PAL, 8: number of palette banks, one per sprite/frame group.
- INDEX_W, 4: colour index width; each bank holds 2**INDEX_W entries.
- COLOR_W, 4: bits per colour channel.
- FADE_DIV, 4: frame_ticks per brightness step.
- FADE_STEP, 2: brightness decrement/increment per step.
- TRANSP_IDX, 0: index value reported as transparent.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- pix_valid  in  1  lookup request this cycle
- pal_sel  in  $clog2(NUM_PAL)  bank select
- index  in  INDEX_W  colour index
- wr_en  in  1  palette entry write strobe
- wr_pal  in  $clog2(NUM_PAL)  write bank
- wr_index  in  INDEX_W  write entry
- wr_rgb  in  3*COLOR_W  {r,g,b} write data
- frame_tick  in  1  one-cycle pulse per vsync
- fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 reserved/ignored
- fade_busy  out  1  high while in FADE_OUT or FADE_IN
- red, green, blue  out  COLOR_W each  scaled colour
- out_valid  out  1  pix_valid delayed by 2
- transparent  out  1  index==TRANSP_IDX, delayed by 2

Behaviour:
- Reset (Reset_n low at posedge):
  - all banks load DEFAULT_PALETTE from the package;
  - red/green/blue = 0, out_valid = 0, transparent = 0;
  - fade FSM = BRIGHT, level = 2**COLOR_W, step counter = 0.
  - Reset asserted mid-fade or mid-pipeline discards everything in flight.
- Stage 1: on a clock edge with pix_valid, register bank[pal_sel][index] into rgb_s1, plus valid_s1 and transp_s1.
- Stage 2: each channel out = (c * level) >> COLOR_W. The product is COLOR_W+LVL_W bits; no rounding.
  - level is sampled at stage 2. A level change mid-frame affects only later pixels.
- Latency is exactly 2 cycles at full throughput (1 pixel/cycle). Bubbles propagate as out_valid = 0.
- While out_valid = 0, rgb outputs hold their previous value.
- Writes: wr_en updates the entry at the clock edge.
  - A same-cycle read of the same entry returns the OLD value (read-before-write).
  - Out-of-range wr_pal (≥ NUM_PAL) is ignored. The same applies to an out-of-range pal_sel read, which returns 0s.
- Fade FSM, with LVL_MAX = 2**COLOR_W:
  - BRIGHT: fade_cmd=01 → FADE_OUT; fade_cmd=10 ignored.
  - FADE_OUT: on each frame_tick, cnt += 1. When cnt == FADE_DIV-1 and a tick arrives: cnt ← 0 and level ← max(level-FADE_STEP, 0). When level reaches 0 → DARK.
  - DARK: fade_cmd=10 → FADE_IN; fade_cmd=01 ignored.
  - FADE_IN: mirror of FADE_OUT, level ← min(level+FADE_STEP, LVL_MAX). Reaching LVL_MAX → BRIGHT.
  - fade_cmd is ignored while fade_busy. cnt clears on every state entry.
- frame_tick and fade_cmd arriving in the same cycle: the command takes effect and the tick is not counted.

Optional Feature:
- Macro: SPRITE_PALETTE_FADE_EN.
- Defined: fade FSM, level register and stage-2 multipliers are present as described.
- Undefined:
  - level is constant LVL_MAX and stage 2 is a plain register (rgb_s2 = rgb_s1);
  - fade_busy is tied 0; fade_cmd and frame_tick are unused;
  - latency stays 2 cycles.

Decomposition:
- Package sprite_palette_pkg:
  - typedef rgb_t, a packed {r,g,b} of COLOR_W each;
  - typedef fade_state_e {BRIGHT, FADE_OUT, DARK, FADE_IN};
  - constant DEFAULT_PALETTE[NUM_PAL][2**INDEX_W] of rgb_t;
  - LVL_MAX.
- One natural sub-module, palette_fade_ctrl: the FSM, step counter and level output. It is instantiated only under SPRITE_PALETTE_FADE_EN.

Test Plan:
- Reset, then pix_valid=1, pal_sel=0, index=0 → 2 cycles later out_valid=1, rgb={A,5,2}, transparent=1. Index=1 → {9,B,3}, transparent=0.
- Back-to-back pixels over 16 indices with a bubble at cycle 5 → outputs match DEFAULT_PALETTE in order, 2-cycle latency, out_valid low exactly one cycle.
- Write bank 3, index 7 = {F,0,F} while reading the same entry that cycle → that read returns the default value; the next read returns {F,0,F}.
- fade_cmd=01, FADE_DIV=4, FADE_STEP=2 → level drops 16→14 after 4 ticks, DARK after 32 ticks. A {A,5,2} pixel at level 8 reads {5,2,1}. fade_cmd=01 in DARK is ignored.
- fade_cmd=10 from DARK → fade_busy high, reaches BRIGHT after 32 ticks. Assert Reset_n=0 at tick 10 → level=16, BRIGHT, outputs 0, out_valid 0.
- Macro undefined: drive fade_cmd=01 plus 40 ticks → colours unchanged, fade_busy=0.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// Shared types, default palette contents and fade constants for sprite_palette_engine.
package sprite_palette_pkg;

  localparam int NUM_PAL_DEF = 8;
  localparam int INDEX_W_DEF = 4;
  localparam int COLOR_W_DEF = 4;
  localparam int PAL_W       = $clog2(NUM_PAL_DEF);
  localparam int ENTRIES     = 2 ** INDEX_W_DEF;
  localparam int LVL_MAX     = 2 ** COLOR_W_DEF;
  localparam int LVL_W       = COLOR_W_DEF + 1;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    BRIGHT,
    FADE_OUT,
    DARK,
    FADE_IN
  } fade_state_e;

  typedef rgb_t  [ENTRIES-1:0]     bank_t;
  typedef bank_t [NUM_PAL_DEF-1:0] pal_array_t;

  // Bank 0 opens with {A,5,2},{9,B,3}; the other entries follow the same
  // per-channel arithmetic progressions so every bank is distinct.
  function automatic pal_array_t build_default_palette();
    pal_array_t pal;
    pal = '0;
    for (int unsigned p = 0; p < NUM_PAL_DEF; p++) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pal[p[PAL_W-1:0]][i[INDEX_W_DEF-1:0]].r = COLOR_W_DEF'(32'd10 - i - p);
        pal[p[PAL_W-1:0]][i[INDEX_W_DEF-1:0]].g = COLOR_W_DEF'(32'd5 + 32'd6 * i + 32'd3 * p);
        pal[p[PAL_W-1:0]][i[INDEX_W_DEF-1:0]].b = COLOR_W_DEF'(32'd2 + i + 32'd2 * p);
      end
    end
    return pal;
  endfunction

  localparam pal_array_t DEFAULT_PALETTE = build_default_palette();

  function automatic logic [COLOR_W_DEF-1:0] scale_channel(
    input logic [COLOR_W_DEF-1:0] c,
    input logic [LVL_W-1:0]       lvl
  );
    logic [COLOR_W_DEF+LVL_W-1:0] prod;
    prod = (COLOR_W_DEF + LVL_W)'(c) * (COLOR_W_DEF + LVL_W)'(lvl);
    return COLOR_W_DEF'(prod >> COLOR_W_DEF);
  endfunction

endpackage

// File: rtl/sprite_palette_engine_fade_ctrl.sv
// Screen-fade FSM: step counter and brightness level for the palette engine.
// Only compiled when SPRITE_PALETTE_FADE_EN is defined.
`ifdef SPRITE_PALETTE_FADE_EN
module palette_fade_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int FADE_DIV  = 4,
  parameter int FADE_STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [1:0]       fade_cmd,
  output logic [LVL_W-1:0] level,
  output logic             fade_busy
);

  localparam int               CNT_W    = $clog2(FADE_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] STEP     = LVL_W'(FADE_STEP);

  fade_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LVL_W-1:0] level_q;
  logic             busy_q;
  logic [LVL_W-1:0] lvl_dn;
  logic [LVL_W-1:0] lvl_up;

  always_comb begin
    lvl_dn = (level_q > STEP) ? level_q - STEP : '0;
    lvl_up = (level_q < LVL_TOP - STEP) ? level_q + STEP : LVL_TOP;
  end

  // Commands are only looked at in the idle states, so a tick arriving with
  // an accepted command never advances the freshly cleared counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BRIGHT;
      cnt_q   <= '0;
      level_q <= LVL_TOP;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        BRIGHT: begin
          if (fade_cmd == 2'b01) begin
            state_q <= FADE_OUT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              level_q <= lvl_dn;
              if (lvl_dn == '0) begin
                state_q <= DARK;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DARK: begin
          if (fade_cmd == 2'b10) begin
            state_q <= FADE_IN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              level_q <= lvl_up;
              if (lvl_up == LVL_TOP) begin
                state_q <= BRIGHT;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign level     = level_q;
  assign fade_busy = busy_q;

endmodule
`endif

// File: rtl/sprite_palette_engine.sv
// Multi-bank writable sprite palette with a 2-stage lookup pipeline.
// Define SPRITE_PALETTE_FADE_EN to add the screen-fade brightness engine.
module sprite_palette_engine
  import sprite_palette_pkg::*;
#(
  parameter int NUM_PAL    = NUM_PAL_DEF,
  parameter int INDEX_W    = INDEX_W_DEF,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int FADE_DIV   = 4,
  parameter int FADE_STEP  = 2,
  parameter int TRANSP_IDX = 0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       pix_valid,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [INDEX_W-1:0]         index,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [INDEX_W-1:0]         wr_index,
  input  logic [3*COLOR_W-1:0]       wr_rgb,
  input  logic                       frame_tick,
  input  logic [1:0]                 fade_cmd,
  output logic                       fade_busy,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic                       out_valid,
  output logic                       transparent
);

  localparam int                    SEL_W      = $clog2(NUM_PAL);
  localparam int                    BANK_SLOTS = 2 ** SEL_W;
  localparam logic [BANK_SLOTS-1:0] BANK_OK    = BANK_SLOTS'((64'd1 << NUM_PAL) - 64'd1);
  localparam logic [INDEX_W-1:0]    TRANSP     = INDEX_W'(TRANSP_IDX);

  pal_array_t         pal_q, pal_d;
  rgb_t               rgb_s1_q, rgb_s1_d;
  rgb_t               rgb_s2;
  logic               valid_s1_q, valid_s1_d;
  logic               transp_s1_q, transp_s1_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               out_valid_q, out_valid_d;
  logic               transparent_q, transparent_d;

  always_comb begin
    pal_d = pal_q;
    if (wr_en && BANK_OK[wr_pal]) begin
      pal_d[wr_pal][wr_index] = wr_rgb;
    end
  end

  // Stage 1 reads pal_q, so a same-cycle write to the entry is seen only by later reads.
  always_comb begin
    rgb_s1_d    = rgb_s1_q;
    valid_s1_d  = pix_valid;
    transp_s1_d = pix_valid && (index == TRANSP);
    if (pix_valid) begin
      rgb_s1_d = BANK_OK[pal_sel] ? pal_q[pal_sel][index] : '0;
    end
  end

`ifdef SPRITE_PALETTE_FADE_EN
  logic [LVL_W-1:0] level;

  palette_fade_ctrl #(
    .FADE_DIV  (FADE_DIV),
    .FADE_STEP (FADE_STEP)
  ) u_fade_ctrl (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_tick (frame_tick),
    .fade_cmd   (fade_cmd),
    .level      (level),
    .fade_busy  (fade_busy)
  );

  always_comb begin
    rgb_s2.r = scale_channel(rgb_s1_q.r, level);
    rgb_s2.g = scale_channel(rgb_s1_q.g, level);
    rgb_s2.b = scale_channel(rgb_s1_q.b, level);
  end
`else
  localparam int unused_fade_cfg = FADE_DIV + FADE_STEP;
  logic unused_fade_inputs;

  assign unused_fade_inputs = ^{fade_cmd, frame_tick};
  assign fade_busy          = 1'b0;
  assign rgb_s2             = rgb_s1_q;
`endif

  always_comb begin
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    out_valid_d   = valid_s1_q;
    transparent_d = transp_s1_q;
    if (valid_s1_q) begin
      red_d   = rgb_s2.r;
      green_d = rgb_s2.g;
      blue_d  = rgb_s2.b;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pal_q         <= DEFAULT_PALETTE;
      rgb_s1_q      <= '0;
      valid_s1_q    <= 1'b0;
      transp_s1_q   <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      out_valid_q   <= 1'b0;
      transparent_q <= 1'b0;
    end else begin
      pal_q         <= pal_d;
      rgb_s1_q      <= rgb_s1_d;
      valid_s1_q    <= valid_s1_d;
      transp_s1_q   <= transp_s1_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      out_valid_q   <= out_valid_d;
      transparent_q <= transparent_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign out_valid   = out_valid_q;
  assign transparent = transparent_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Scoreboard bench for sprite_palette_engine; expectations follow SPRITE_PALETTE_FADE_EN.
module tb_sprite_palette_engine;

`ifdef SPRITE_PALETTE_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid;
  logic [2:0]  pal_sel;
  logic [3:0]  index;
  logic        wr_en;
  logic [2:0]  wr_pal;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        frame_tick;
  logic [1:0]  fade_cmd;
  logic        fade_busy;
  logic [3:0]  red, green, blue;
  logic        out_valid;
  logic        transparent;

  sprite_palette_engine #(
    .NUM_PAL    (8),
    .INDEX_W    (4),
    .COLOR_W    (4),
    .FADE_DIV   (4),
    .FADE_STEP  (2),
    .TRANSP_IDX (0)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_valid   (pix_valid),
    .pal_sel     (pal_sel),
    .index       (index),
    .wr_en       (wr_en),
    .wr_pal      (wr_pal),
    .wr_index    (wr_index),
    .wr_rgb      (wr_rgb),
    .frame_tick  (frame_tick),
    .fade_cmd    (fade_cmd),
    .fade_busy   (fade_busy),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .out_valid   (out_valid),
    .transparent (transparent)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned due;
    bit          valid;
    logic [11:0] rgb;
    bit          transp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  logic [11:0] last_rgb = 12'h000;
  logic [11:0] mem [8][16];
  int          exp_level = 16;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [11:0] def_rgb(input int p, input int i);
    int r, g, b;
    r = (42 - i - p) % 16;
    g = (5 + 6 * i + 3 * p) % 16;
    b = (2 + i + 2 * p) % 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [11:0] dim(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = int'(c[11:8]) * lvl / 16;
    g = int'(c[7:4]) * lvl / 16;
    b = int'(c[3:0]) * lvl / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic load_model();
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 16; i++)
        mem[p][i] = def_rgb(p, i);
    exp_level = 16;
    last_rgb  = 12'h000;
  endtask

  task automatic push_raw(input bit v, input logic [11:0] rgb, input bit tr, input string nm);
    exp_t e;
    e.due = cyc + 2; e.valid = v; e.rgb = rgb; e.transp = tr; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input bit v, input int p, input int i, input string nm);
    @(negedge Clk);
    pix_valid = v; pal_sel = 3'(p); index = 4'(i);
    push_raw(v, v ? dim(mem[p][i], exp_level) : 12'h000, v && (i == 0), nm);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    @(negedge Clk);
    pix_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: %0d results pending, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic pix(input int p, input int i, input string nm);
    drive(1'b1, p, i, nm);
    drain(nm);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge Clk); frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [1:0] c, input bit with_tick);
    @(negedge Clk); fade_cmd = c; frame_tick = with_tick;
    @(negedge Clk); fade_cmd = 2'b00; frame_tick = 1'b0;
  endtask

  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        vectors++;
        if (out_valid !== e.valid) begin
          miscompares++;
          $display("FAIL %s_valid: got %0b required %0b", e.name, out_valid, e.valid);
        end else if (e.valid && ({red, green, blue} !== e.rgb || transparent !== e.transp)) begin
          miscompares++;
          $display("FAIL %s: got rgb=%03h transp=%0b required rgb=%03h transp=%0b",
                   e.name, {red, green, blue}, transparent, e.rgb, e.transp);
        end else if (!e.valid && {red, green, blue} !== last_rgb) begin
          miscompares++;
          $display("FAIL %s_hold: got rgb=%03h required %03h", e.name, {red, green, blue}, last_rgb);
        end
        if (e.valid) last_rgb = e.rgb;
      end else begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_valid: got out_valid=%0b required 0 at cycle %0d", out_valid, cyc);
        end
      end
    end
  end

  task automatic test_reset();
    mon_en = 1'b0; Reset_n = 1'b0;
    pix_valid = 1'b0; pal_sel = '0; index = '0;
    wr_en = 1'b0; wr_pal = '0; wr_index = '0; wr_rgb = '0;
    frame_tick = 1'b0; fade_cmd = 2'b00;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({red, green, blue} !== 12'h000) begin
      miscompares++; $display("FAIL reset_rgb: got %03h required 000", {red, green, blue});
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %0b required 0", out_valid);
    end
    vectors++;
    if (transparent !== 1'b0) begin
      miscompares++; $display("FAIL reset_transp: got %0b required 0", transparent);
    end
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %0b required 0", fade_busy);
    end
    Reset_n = 1'b1;
    load_model();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge Clk); pix_valid = 1'b1; pal_sel = 3'd0; index = 4'd0;
    push_raw(1'b1, 12'hA52, 1'b1, "basic_idx0");
    @(negedge Clk); index = 4'd1;
    push_raw(1'b1, 12'h9B3, 1'b0, "basic_idx1");
    drain("basic");
  endtask

  task automatic test_back_to_back();
    int idx;
    idx = 0;
    for (int slot = 0; slot < 17; slot++) begin
      if (slot == 5) drive(1'b0, 2, 0, "b2b_bubble");
      else begin
        drive(1'b1, 2, idx, "b2b_pixel");
        idx++;
      end
    end
    drain("b2b");
  endtask

  task automatic test_write_rbw();
    @(negedge Clk);
    pix_valid = 1'b1; pal_sel = 3'd3; index = 4'd7;
    wr_en = 1'b1; wr_pal = 3'd3; wr_index = 4'd7; wr_rgb = 12'hF0F;
    push_raw(1'b1, def_rgb(3, 7), 1'b0, "rbw_old");
    mem[3][7] = 12'hF0F;
    @(negedge Clk);
    wr_en = 1'b0;
    push_raw(1'b1, 12'hF0F, 1'b0, "rbw_new");
    @(negedge Clk);
    index = 4'd6;
    push_raw(1'b1, def_rgb(3, 6), 1'b0, "rbw_neighbour");
    @(negedge Clk);
    pix_valid = 1'b0;
    wr_en = 1'b1; wr_pal = 3'd7; wr_index = 4'd0; wr_rgb = 12'h123;
    mem[7][0] = 12'h123;
    @(negedge Clk);
    wr_en = 1'b0;
    drain("rbw");
    pix(7, 0, "wr_bank7");
  endtask

  task automatic test_fade_out();
    send_cmd(2'b01, 1'b0);
    vectors++;
    if (fade_busy !== FADE_ON) begin
      miscompares++; $display("FAIL fo_busy_start: got %0b required %0b", fade_busy, FADE_ON);
    end
    ticks(3);
    pix(0, 0, "fo_3ticks");
    ticks(1);
    exp_level = FADE_ON ? 14 : 16;
    @(negedge Clk); pix_valid = 1'b1; pal_sel = 3'd0; index = 4'd0;
    push_raw(1'b1, FADE_ON ? 12'h841 : 12'hA52, 1'b1, "fo_lvl14");
    drain("fo_lvl14");
    ticks(12);
    exp_level = FADE_ON ? 8 : 16;
    @(negedge Clk); pix_valid = 1'b1; pal_sel = 3'd0; index = 4'd0;
    push_raw(1'b1, FADE_ON ? 12'h521 : 12'hA52, 1'b1, "fo_lvl8");
    drain("fo_lvl8");
    ticks(15);
    exp_level = FADE_ON ? 2 : 16;
    pix(0, 1, "fo_lvl2");
    vectors++;
    if (fade_busy !== FADE_ON) begin
      miscompares++; $display("FAIL fo_busy_31: got %0b required %0b", fade_busy, FADE_ON);
    end
    ticks(1);
    exp_level = FADE_ON ? 0 : 16;
    pix(0, 1, "fo_dark");
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL fo_busy_dark: got %0b required 0", fade_busy);
    end
    send_cmd(2'b01, 1'b0);
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL dark_ignore_out: got %0b required 0", fade_busy);
    end
    ticks(4);
    pix(0, 0, "dark_hold");
  endtask

  task automatic test_fade_in();
    send_cmd(2'b10, 1'b1);
    vectors++;
    if (fade_busy !== FADE_ON) begin
      miscompares++; $display("FAIL fi_busy_start: got %0b required %0b", fade_busy, FADE_ON);
    end
    ticks(3);
    pix(0, 0, "fi_tick_not_counted");
    ticks(1);
    exp_level = FADE_ON ? 2 : 16;
    @(negedge Clk); pix_valid = 1'b1; pal_sel = 3'd0; index = 4'd0;
    push_raw(1'b1, FADE_ON ? 12'h100 : 12'hA52, 1'b1, "fi_lvl2");
    drain("fi_lvl2");
    ticks(5);
    @(negedge Clk);
    mon_en = 1'b0; pix_valid = 1'b1; pal_sel = 3'd0; index = 4'd1;
    @(negedge Clk);
    pix_valid = 1'b0; Reset_n = 1'b0;
    @(negedge Clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midreset_valid: got %0b required 0", out_valid);
    end
    vectors++;
    if ({red, green, blue} !== 12'h000) begin
      miscompares++; $display("FAIL midreset_rgb: got %03h required 000", {red, green, blue});
    end
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_busy: got %0b required 0", fade_busy);
    end
    Reset_n = 1'b1;
    load_model();
    mon_en = 1'b1;
    pix(0, 0, "midreset_full_level");
  endtask

  task automatic test_fade_full();
    send_cmd(2'b01, 1'b0);
    ticks(32);
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL full_dark_busy: got %0b required 0", fade_busy);
    end
    exp_level = FADE_ON ? 0 : 16;
    pix(5, 9, "full_dark");
    send_cmd(2'b10, 1'b0);
    ticks(31);
    vectors++;
    if (fade_busy !== FADE_ON) begin
      miscompares++; $display("FAIL full_in_busy: got %0b required %0b", fade_busy, FADE_ON);
    end
    exp_level = FADE_ON ? 14 : 16;
    pix(5, 9, "full_in_lvl14");
    ticks(1);
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL full_bright_busy: got %0b required 0", fade_busy);
    end
    exp_level = 16;
    pix(5, 9, "full_bright");
    send_cmd(2'b10, 1'b0);
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++; $display("FAIL bright_ignore_in: got %0b required 0", fade_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_write_rbw();
    test_fade_out();
    test_fade_in();
    test_fade_full();
    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
